// File: rtl/starter_byte_packer_if.sv
// starter_byte_packer_if
//   Groups the byte-stream input and the word-stream output of the packer.
//   slave  : packer side (consumes data/valid/flush, produces the word stream)
//   master : upstream/downstream side (drives bytes and out_ready)
//   Signals:
//     data[7:0], valid, flush         byte stream in, no backpressure
//     out_data[31:0], out_bytes[2:0]  head word and its count of valid bytes
//     out_valid, out_ready            word handshake
//     level[LVL_W-1:0], overflow      occupancy and sticky drop flag
interface starter_byte_packer_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
);
  logic [7:0]       data;
  logic             valid;
  logic             flush;
  logic [31:0]      out_data;
  logic [2:0]       out_bytes;
  logic             out_valid;
  logic             out_ready;
  logic [LVL_W-1:0] level;
  logic             overflow;

  modport master (
    output data, valid, flush, out_ready,
    input  out_data, out_bytes, out_valid, level, overflow
  );

  modport slave (
    input  data, valid, flush, out_ready,
    output out_data, out_bytes, out_valid, level, overflow
  );
endinterface

// File: rtl/starter_byte_packer.sv
// starter_byte_packer
//   Packs an 8-bit byte stream little-endian into 32-bit words (first byte in
//   bits [7:0]), buffers them in a first-word-fall-through FIFO and offers
//   them on a valid/ready handshake. flush closes a partial word; overflow is
//   a sticky flag set whenever a completed word finds the FIFO full with no
//   pop in the same cycle.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-low reset
//     bus  starter_byte_packer_if.slave (byte stream in, word stream out)
module starter_byte_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  starter_byte_packer_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Byte assembly
  // ---------------------------------------------------------------------------
  logic [23:0] acc_reg, acc_next;
  logic [1:0]  idx_reg, idx_next;
  logic [31:0] acc_ext;
  logic [31:0] merged;
  logic        close;
  logic [2:0]  word_bytes;

  assign acc_ext = {8'h00, acc_reg};

  // merged is the pending bytes with the incoming byte dropped into lane idx.
  // It serves both as the next accumulator and as the word to push, so the
  // flush-with-byte and 4th-byte cases need no separate datapath.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = (bus.valid && (idx_reg == 2'(gi))) ? bus.data
                                                                     : acc_ext[8*gi +: 8];
    end
  endgenerate

  // A word closes on the 4th byte, or on flush when at least one byte
  // (pending or arriving now) exists; an empty word is never produced.
  assign close      = bus.valid ? ((idx_reg == 2'd3) || bus.flush)
                                : (bus.flush && (idx_reg != 2'd0));
  assign word_bytes = {1'b0, idx_reg} + {2'b00, bus.valid};

  always_comb begin
    acc_next = acc_reg;
    idx_next = idx_reg;
    if (close) begin
      acc_next = '0;
      idx_next = '0;
    end else if (bus.valid) begin
      acc_next = merged[23:0];
      idx_next = idx_reg + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  // Entry layout: {bytes[2:0], word[31:0]}
  logic [34:0]      mem [FIFO_DEPTH];
  logic [34:0]      head;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             overflow_reg, overflow_next;
  logic             empty, full, pop, wr_en, drop;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LVL_W'(FIFO_DEPTH));
  assign pop   = !empty && bus.out_ready;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign wr_en = close && (!full || pop);
  assign drop  = close && full && !pop;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    overflow_next = overflow_reg | drop;
    if (wr_en) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop)   rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    case ({wr_en, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg      <= '0;
      idx_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      acc_reg      <= acc_next;
      idx_reg      <= idx_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage needs no reset: every read is masked by level, so stale entries
  // are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {word_bytes, merged};
  end

  // Head is read combinationally so a word written at edge N is presented in
  // cycle N+1 (fall-through).
  assign head          = mem[rd_ptr_reg];
  assign bus.out_data  = empty ? 32'h0 : head[31:0];
  assign bus.out_bytes = empty ? 3'd0  : head[34:32];
  assign bus.out_valid = !empty;
  assign bus.level     = level_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: doc/starter_byte_packer.md
# starter_byte_packer

Receive-side stage that consumes the 8-bit starter data stream (`data`/`valid`, no backpressure) and packs bytes into 32-bit words. Bytes are packed little-endian: the first byte lands in bits [7:0]. Completed words are buffered in a first-word-fall-through FIFO and offered downstream on a valid/ready handshake. A flush input closes a partial word, and a sticky flag records any word lost to FIFO overflow.

## Interface
Parameters:
- `FIFO_DEPTH`, 8, number of 32-bit word entries; power of two, minimum 2.
- `LVL_W`, `$clog2(FIFO_DEPTH)+1`, width of `level`; derived, do not override.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `data`  input  8  incoming byte; sampled only when `valid`=1.
- `valid`  input  1  byte strobe; one byte per cycle, no stall possible.
- `flush`  input  1  single-cycle request to emit the partial word.
- `out_data`  output  32  head FIFO word; unused upper bytes are 0.
- `out_bytes`  output  3  count of valid bytes in `out_data`, 1..4.
- `out_valid`  output  1  FIFO non-empty.
- `out_ready`  input  1  downstream accepts the head word.
- `level`  output  LVL_W  current FIFO occupancy, 0..FIFO_DEPTH.
- `overflow`  output  1  sticky; a completed word was dropped.

## Operation
- Assembly state: `acc[23:0]` holds up to 3 pending bytes; `idx` (0..3) is the count of pending bytes.
- `valid`=1 with `idx`<3: `acc[8*idx +: 8]` <= `data`, then `idx`++.
- `valid`=1 with `idx`==3: push word {`data`, `acc[23:0]`} with bytes=4; `idx` <= 0, `acc` <= 0.
- `flush`=1, `valid`=0, `idx`>0: push word {zero-padded `acc`} with bytes=`idx`; clear `idx` and `acc`.
- `flush`=1, `valid`=1: the current byte is included first, then the word closes.
  - Bytes = `idx`+1.
  - If `idx`==3, this is the ordinary full-word push, and only one word is pushed.
- `flush` with `idx`==0 and `valid`=0: no-op. No empty word is ever pushed.
- Pop occurs when `out_valid`=1 and `out_ready`=1.
- Push when FIFO full:
  - With a pop in the same cycle: the push is accepted and `level` is unchanged.
  - Without a pop: the word is discarded, FIFO contents are unchanged, and `overflow` <= 1.
- `overflow` clears only on reset.
- Push and pop in the same cycle with a non-empty FIFO: `level` is unchanged and order is preserved.
- Push and pop in the same cycle with an empty FIFO: impossible, since `out_valid`=0.
- FIFO pointers wrap modulo `FIFO_DEPTH`. `level` is an explicit counter, so full (`FIFO_DEPTH`) and empty (0) are distinguished.
- When empty, `out_data`=0 and `out_bytes`=0.
- Reset while asserted, with all outputs at the values below:
  - Clears `acc`, `idx`, the FIFO pointers and `level`.
  - Drops any partial word and all buffered words.
- Reset values: `out_data`=0, `out_bytes`=0, `out_valid`=0, `level`=0, `overflow`=0.

## Timing
- Completing byte (or flush) sampled at edge N: the word is written at edge N; `out_valid`=1 and `out_data` are valid after edge N (visible in cycle N+1) when the FIFO was empty.
- Latency from the 4th byte to `out_valid` is one cycle.
- `out_data`/`out_bytes` are stable while `out_valid`=1 and `out_ready`=0.
- Head advances one entry per accepted pop. Throughput is up to 1 word/cycle out; input supplies at most 1 word per 4 cycles, except flush-dense traffic.
- `overflow` rises at the edge where the word is dropped.
- `rst` deassertion is assumed synchronised externally. The first byte is accepted at the first rising edge after deassertion.

## Test plan
- Bytes 0x11,0x22,0x33,0x44 on consecutive cycles, `out_ready`=1 -> one cycle later `out_data`=0x44332211, `out_bytes`=4, `out_valid` high for exactly 1 cycle.
- Bytes 0xAA,0xBB, then `flush` alone -> `out_data`=0x0000BBAA, `out_bytes`=2; following 4 bytes form a clean new word.
- Bytes 0x01,0x02, then 0x03 with `flush` in the same cycle -> `out_data`=0x00030201, `out_bytes`=3, single push.
- `FIFO_DEPTH`=8, `out_ready`=0, 9 full words fed -> `level`=8 and `overflow`=1 after the 9th word. Then `out_ready`=1 -> exactly words 1..8 drain in order and `level` returns to 0.
- FIFO full and `out_ready`=1 while a 4th byte arrives -> push accepted, `level` stays 8, `overflow` stays 0.
- Bytes 0x55,0x66, assert `rst` mid-word (also with 3 words buffered), release, feed 0x01..0x04 -> all outputs at reset values during reset; the only word out is 0x04030201.
